// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared constants and types for the compare scheduler
package comp_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] CMP_GT = 3'b000;
  localparam logic [2:0] CMP_GE = 3'b001;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_LE = 3'b011;
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_NE = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Codes 110 and 111 have no meaning for the comparator.
  function automatic logic ctrl_illegal(input logic [2:0] ctrl);
    return ctrl[2] & ctrl[1];
  endfunction

endpackage

// File: rtl/comp_dcd.sv
// rtl/comp_dcd.sv - decodes less/equal flags into a condition result
module comp_dcd
  import comp_pkg::*;
(
  input  logic [2:0] ctrl,
  input  logic       less,
  input  logic       eql,
  output logic       z
);

  always_comb begin
    z = 1'b0;
    case (ctrl)
      CMP_GT:  z = ~less & ~eql;
      CMP_GE:  z = ~less;
      CMP_LT:  z = less;
      CMP_LE:  z = less | eql;
      CMP_EQ:  z = eql;
      CMP_NE:  z = ~eql;
      default: z = 1'b0;
    endcase
  end

endmodule

// File: rtl/comp_sched.sv
// rtl/comp_sched.sv - round-robin scheduler sharing one signed comparator between two requesters
module comp_sched
  import comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;

  logic grant0, grant1;
  logic less, eql, dcd_z, illegal;

  assign less    = $signed(a_q) < $signed(b_q);
  assign eql     = (a_q == b_q);
  assign illegal = ctrl_illegal(ctrl_q);

  comp_dcd u_dcd (
    .ctrl (ctrl_q),
    .less (less),
    .eql  (eql),
    .z    (dcd_z)
  );

  // rr_ptr only breaks ties; a lone valid requester is always granted.
  assign grant0 = req0_valid & (~req1_valid | ~rr_ptr_q);
  assign grant1 = req1_valid & (~req0_valid | rr_ptr_q);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    id_d       = id_q;
    rsp_z_d    = rsp_z_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0) begin
          a_d      = req0_a;
          b_d      = req0_b;
          ctrl_d   = req0_ctrl;
          id_d     = 1'b0;
          rr_ptr_d = 1'b1;
          state_d  = EXEC;
        end else if (grant1) begin
          a_d      = req1_a;
          b_d      = req1_b;
          ctrl_d   = req1_ctrl;
          id_d     = 1'b1;
          rr_ptr_d = 1'b0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_z_d   = {{(WIDTH-1){1'b0}}, dcd_z & ~illegal};
        rsp_id_d  = id_q;
        rsp_err_d = illegal;
        state_d   = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      id_q      <= 1'b0;
      rsp_z_q   <= '0;
      rsp_id_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      rsp_z_q   <= rsp_z_d;
      rsp_id_q  <= rsp_id_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Operand latches carry no reset: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    ctrl_q <= ctrl_d;
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_err   = rsp_err_q;

endmodule
